mem_port_arbiter: RTL and testbench

//  Shares one unified memory port between the pipeline's instruction-fetch port and its

---
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one req/ack memory port between fetch and data; data wins, bounded by a streak limit.
// Latency: grant -> mem_req next cycle -> ready one cycle after ack (min 3); requesters hold until ready.
module mem_port_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int MAX_D_STREAK = 4,
    parameter int ACK_TIMEOUT  = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req_i,
    input  logic [AW-1:0] if_addr_i,
    output logic [DW-1:0] if_rdata_o,
    output logic          if_ready_o,
    input  logic          dm_req_i,
    input  logic          dm_we_i,
    input  logic [AW-1:0] dm_addr_i,
    input  logic [DW-1:0] dm_wdata_i,
    input  logic [2:0]    dm_type_i,
    output logic [DW-1:0] dm_rdata_o,
    output logic          dm_ready_o,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    output logic [2:0]    mem_type_o,
    input  logic          mem_ack_i,
    input  logic [DW-1:0] mem_rdata_i,
    output logic          err_o,
    output logic          owner_o
);

    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

    state_t        state_q;
    logic [SW-1:0] streak_q, streak_d;
    logic [TW-1:0] tmo_q;
    logic          grant_d, grant_i, timeout_hit;

    logic [DW-1:0] if_rdata_q, dm_rdata_q, mem_wdata_q;
    logic [AW-1:0] mem_addr_q;
    logic [2:0]    mem_type_q;
    logic          if_ready_q, dm_ready_q, mem_req_q, mem_we_q, err_q, owner_q;

    // Fetch only beats a pending data request once the data streak is exhausted.
    always_comb begin
        grant_d     = dm_req_i && (!if_req_i || (streak_q < SW'(MAX_D_STREAK)));
        grant_i     = if_req_i && !grant_d;
        timeout_hit = (tmo_q == TW'(ACK_TIMEOUT - 1));
        streak_d    = streak_q;
        if (grant_d) begin
            if (!if_req_i)
                streak_d = '0;
            else if (streak_q != SW'(MAX_D_STREAK))
                streak_d = streak_q + SW'(1);
        end else if (grant_i) begin
            streak_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            tmo_q       <= '0;
            if_rdata_q  <= '0;
            if_ready_q  <= 1'b0;
            dm_rdata_q  <= '0;
            dm_ready_q  <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_type_q  <= '0;
            err_q       <= 1'b0;
            owner_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    streak_q <= streak_d;
                    tmo_q    <= '0;
                    if (grant_d) begin
                        state_q     <= BUSY_D;
                        owner_q     <= 1'b1;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= dm_we_i;
                        mem_addr_q  <= dm_addr_i;
                        mem_wdata_q <= dm_wdata_i;
                        mem_type_q  <= dm_type_i;
                    end else if (grant_i) begin
                        state_q     <= BUSY_I;
                        owner_q     <= 1'b0;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= if_addr_i;
                        mem_wdata_q <= '0;
                        mem_type_q  <= 3'b000;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (mem_ack_i || timeout_hit) begin
                        state_q   <= DONE;
                        mem_req_q <= 1'b0;
                        err_q     <= !mem_ack_i;
                        if (state_q == BUSY_I) begin
                            if_ready_q <= 1'b1;
                            if_rdata_q <= mem_ack_i ? mem_rdata_i : '0;
                        end else begin
                            dm_ready_q <= 1'b1;
                            dm_rdata_q <= (mem_ack_i && !mem_we_q) ? mem_rdata_i : '0;
                        end
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                DONE: begin
                    state_q    <= IDLE;
                    if_ready_q <= 1'b0;
                    dm_ready_q <= 1'b0;
                    err_q      <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign if_rdata_o  = if_rdata_q;
    assign if_ready_o  = if_ready_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign dm_ready_o  = dm_ready_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_type_o  = mem_type_q;
    assign err_o       = err_q;
    assign owner_o     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random requesters and memory against a transaction-schedule model of the arbiter.
// Each grant is predicted from the priority/streak rule; its timeline follows from the chosen ack delay.
module tb_mem_port_arbiter;
    localparam int MAXS = 4;
    localparam int TMO  = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        if_req, dm_req, dm_we, mem_ack;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [2:0]  dm_type;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic [2:0]  mem_type;
    logic        if_ready, dm_ready, mem_req, mem_we, err, owner;

    mem_port_arbiter #(.AW(32), .DW(32), .MAX_D_STREAK(MAXS), .ACK_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_ready_o(if_ready),
        .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
        .dm_type_i(dm_type), .dm_rdata_o(dm_rdata), .dm_ready_o(dm_ready),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_type_o(mem_type), .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata),
        .err_o(err), .owner_o(owner)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Transaction schedule: grant cycle, ack cycle, ready cycle, first cycle free to arbitrate.
    int          cyc, g_cyc, ack_cyc, done_cyc, free_cyc, streak, w, rate, n_rst;
    bit          busy, tx_own, tx_err, tx_we, own_exp, if_pend, dm_pend, win_d;
    logic [31:0] tx_addr, tx_wdata, tx_rdata;
    logic [2:0]  tx_type;

    task automatic model_reset();
        busy = 0; if_pend = 0; dm_pend = 0; streak = 0; own_exp = 0;
        g_cyc = -100; ack_cyc = -100; done_cyc = -100; free_cyc = 0;
        if_req = 0; dm_req = 0; mem_ack = 0;
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "mem_req"},  32'(mem_req), 0);
        chk({pfx, "mem_we"},   32'(mem_we), 0);
        chk({pfx, "mem_addr"}, mem_addr, 0);
        chk({pfx, "mem_wdata"}, mem_wdata, 0);
        chk({pfx, "mem_type"}, 32'(mem_type), 0);
        chk({pfx, "if_ready"}, 32'(if_ready), 0);
        chk({pfx, "dm_ready"}, 32'(dm_ready), 0);
        chk({pfx, "if_rdata"}, if_rdata, 0);
        chk({pfx, "dm_rdata"}, dm_rdata, 0);
        chk({pfx, "err"},      32'(err), 0);
        chk({pfx, "owner"},    32'(owner), 0);
    endtask

    task automatic check_cycle();
        bit mreq, rdy;
        mreq = busy && (cyc > g_cyc) && (cyc < done_cyc);
        rdy  = busy && (cyc == done_cyc);
        chk("mem_req",  32'(mem_req),  32'(mreq));
        chk("if_ready", 32'(if_ready), 32'(rdy && !tx_own));
        chk("dm_ready", 32'(dm_ready), 32'(rdy && tx_own));
        chk("err",      32'(err),      32'(rdy && tx_err));
        chk("owner",    32'(owner),    32'(own_exp));
        if (mreq) begin
            chk("mem_we",    32'(mem_we), 32'(tx_we));
            chk("mem_addr",  mem_addr, tx_addr);
            chk("mem_wdata", mem_wdata, tx_wdata);
            chk("mem_type",  32'(mem_type), 32'(tx_type));
        end
        if (rdy && !tx_own) chk("if_rdata", if_rdata, tx_rdata);
        if (rdy && tx_own)  chk("dm_rdata", dm_rdata, tx_rdata);
    endtask

    // Async reset while BUSY with the ack due next cycle: outputs clear at once, no ready follows.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk_all_zero("rstbusy_");
        mem_ack = 1'b1;
        @(posedge clk); #1;
        chk_all_zero("rsthold_");
        model_reset();
        #2 rst_n = 1'b1;
        n_rst++;
    endtask

    initial begin
        if_addr = 0; dm_addr = 0; dm_wdata = 0; dm_we = 0; dm_type = 0; mem_rdata = 0;
        n_rst = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        chk_all_zero("reset_");
        cyc = 0;
        for (int it = 0; it < 4000; it++) begin
            @(posedge clk); #1;
            cyc++;
            // Phase 1 keeps both requesters permanently asserted to exercise the streak limit.
            rate = (it < 1200) ? 100 : ((it < 2400) ? 25 : 60);
            check_cycle();
            if (busy && cyc == done_cyc) begin
                busy = 0;
                if (tx_own) dm_pend = 0; else if_pend = 0;
            end
            if (it >= 2800 && n_rst < 6 && busy && !tx_err && cyc > g_cyc &&
                cyc == ack_cyc - 1 && $urandom_range(2) == 0) begin
                do_reset();
                continue;
            end

            if (!if_pend && $urandom_range(99) < rate) begin
                if_pend = 1; if_req = 1; if_addr = $urandom;
            end
            if (!dm_pend && $urandom_range(99) < rate) begin
                dm_pend = 1; dm_req = 1; dm_addr = $urandom; dm_wdata = $urandom;
                dm_we = 1'($urandom_range(1)); dm_type = 3'($urandom_range(7));
            end
            if (busy && !tx_own && $urandom_range(7) == 0) if_req = 0;
            if (busy && tx_own && $urandom_range(7) == 0)  dm_req = 0;
            if (!if_pend) if_req = 0;
            if (!dm_pend) dm_req = 0;

            if (cyc >= free_cyc && (if_req || dm_req)) begin
                win_d = dm_req && (!if_req || streak < MAXS);
                if (win_d) streak = if_req ? ((streak < MAXS) ? streak + 1 : MAXS) : 0;
                else       streak = 0;
                tx_own   = win_d;
                own_exp  = win_d;
                tx_we    = win_d ? dm_we : 1'b0;
                tx_addr  = win_d ? dm_addr : if_addr;
                tx_wdata = win_d ? dm_wdata : 32'h0;
                tx_type  = win_d ? dm_type : 3'b000;
                w = (it < 600 && $urandom_range(1) == 0) ? 0 : $urandom_range(TMO + 3);
                g_cyc = cyc;
                if (w < TMO) begin
                    ack_cyc = g_cyc + 1 + w; done_cyc = ack_cyc + 1; tx_err = 0;
                end else begin
                    ack_cyc = -100; done_cyc = g_cyc + 1 + TMO; tx_err = 1; tx_rdata = 0;
                end
                free_cyc = done_cyc + 1;
                busy = 1;
            end

            mem_rdata = $urandom;
            if (busy && cyc == ack_cyc) begin
                mem_ack  = 1'b1;
                tx_rdata = (tx_own && tx_we) ? 32'h0 : mem_rdata;
            end else if (!(busy && cyc > g_cyc && cyc < done_cyc)) begin
                mem_ack = ($urandom_range(4) == 0);
            end else begin
                mem_ack = 1'b0;
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
